// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and data requesters; data has priority, bounded by a starvation counter.
// Latency: one arbitration cycle, then grant until ramready; outputs are combinational from state and live requests.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             dreq;
    logic             i_done;
    logic             d_done;

    assign dreq   = dREN | dWEN;
    // A withdrawn request masks ramready, so completion needs the request still present.
    assign i_done = (state == IGRANT) && iREN && ramready;
    assign d_done = (state == DGRANT) && dreq && ramready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && (!iREN || (starve_cnt < STARVE_LIM)))
                        state <= DGRANT;
                    else if (iREN)
                        state <= IGRANT;
                end
                IGRANT: if (!iREN || ramready) state <= IDLE;
                DGRANT: if (!dreq || ramready) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!iREN || i_done)
                starve_cnt <= '0;
            else if (d_done && (starve_cnt < STARVE_LIM))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DGRANT: begin
                // Write wins when both enables are asserted.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iload = i_done ? ramload : '0;
    assign dload = d_done ? ramload : '0;
    assign iwait = iREN & ~i_done;
    assign dwait = dreq & ~d_done;

endmodule
